// File: rtl/trigger_hls_deadlock_monitor_v2.sv
// trigger_hls_deadlock_monitor_v2
// Deadlock monitor for one HLS dataflow instance. A stall (any AXIS channel
// blocked, or any non-idle sub-instance blocked) must persist for `threshold`
// consecutive enabled cycles before `block` is raised. At detection the
// blocked channels are captured and a saturating event counter advances.
// Optional feature macro: DEADLOCK_MON_STICKY_EN
//   defined   -> BLOCKED is left only by clear or reset
//   undefined -> BLOCKED drops on the first edge without an enabled stall
module trigger_hls_deadlock_monitor_v2 #(
  parameter int N_AXIS = 7,
  parameter int N_INST = 1,
  parameter int CNT_W  = 16,
  parameter int EVT_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [CNT_W-1:0]  threshold,
  input  logic              clear,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_INST-1:0] inst_idle_sigs,
  input  logic [N_INST-1:0] inst_block_sigs,
  output logic              block,
  output logic [N_AXIS-1:0] block_axis_mask,
  output logic [N_INST-1:0] block_inst_mask,
  output logic [EVT_W-1:0]  block_event_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [EVT_W-1:0] EVT_MAX = {EVT_W{1'b1}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [CNT_W-1:0]  w_thr_eff;
  logic              r_block;
  logic              w_block_nxt;
  logic              w_capture;
  logic [N_INST-1:0] w_inst_qual;
  logic              w_stall;
  logic              w_go;
  logic [N_AXIS-1:0] r_axis_mask;
  logic [N_INST-1:0] r_inst_mask;
  logic [EVT_W-1:0]  r_evt;

  // An idle sub-instance reporting "blocked" is not a real stall.
  assign w_inst_qual = inst_block_sigs & ~inst_idle_sigs;
  assign w_stall     = (|axis_block_sigs) | (|w_inst_qual);
  assign w_go        = w_stall & enable;

  // A zero threshold behaves like one: detection after a single stall cycle.
  assign w_thr_eff = (threshold == '0) ? CNT_ONE : threshold;

  // Counter never wraps; at full scale it sticks (and then always meets threshold).
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);

  // State register with persistence counter and registered block flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_block <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_block <= w_block_nxt;
    end
  end

  // Next-state and next-counter selection; clear overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_nxt = '0;
          if (w_go) begin
            w_cnt_nxt = CNT_ONE;
            if (w_thr_eff <= CNT_ONE) begin
              w_state_nxt = ST_BLOCKED;
            end else begin
              w_state_nxt = ST_COUNT;
            end
          end
        end
        ST_COUNT: begin
          if (w_go) begin
            w_cnt_nxt = w_cnt_inc;
            // Threshold is live: lowering it below the count blocks on this edge.
            if (w_cnt_inc >= w_thr_eff) begin
              w_state_nxt = ST_BLOCKED;
            end
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        ST_BLOCKED: begin
`ifdef DEADLOCK_MON_STICKY_EN
          w_state_nxt = ST_BLOCKED;
`else
          if (!w_go) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
`endif
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output decode: block follows the next state; capture fires only on BLOCKED entry.
  always_comb begin
    w_block_nxt = (w_state_nxt == ST_BLOCKED);
    w_capture   = (r_state != ST_BLOCKED) && (w_state_nxt == ST_BLOCKED);
  end

  // Snapshot of the blocked channels at detection, held until clear/next detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_axis_mask <= '0;
      r_inst_mask <= '0;
    end else if (clear) begin
      r_axis_mask <= '0;
      r_inst_mask <= '0;
    end else if (w_capture) begin
      r_axis_mask <= axis_block_sigs;
      r_inst_mask <= w_inst_qual;
    end
  end

  // Saturating detection counter; clear deliberately leaves it alone.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_evt <= '0;
    end else if (w_capture && (r_evt != EVT_MAX)) begin
      r_evt <= r_evt + EVT_W'(1);
    end
  end

  assign block             = r_block;
  assign block_axis_mask   = r_axis_mask;
  assign block_inst_mask   = r_inst_mask;
  assign block_event_count = r_evt;

endmodule

// File: tb/tb_trigger_hls_deadlock_monitor_v2.sv
// Bench for trigger_hls_deadlock_monitor_v2: directed scenarios followed by
// randomized traffic, all checked through a scoreboard fed by a run-length
// reference model. A second instance with EVT_W=2 checks counter saturation.
module tb_trigger_hls_deadlock_monitor_v2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] threshold;
  logic        clear;
  logic [6:0]  axis;
  logic [0:0]  idle;
  logic [0:0]  iblk;

  logic        block;
  logic [6:0]  axis_mask;
  logic [0:0]  inst_mask;
  logic [7:0]  evt8;
  logic        block2;
  logic [6:0]  axis_mask2;
  logic [0:0]  inst_mask2;
  logic [1:0]  evt2;

  int n_tests = 0;
  int n_fail  = 0;

  trigger_hls_deadlock_monitor_v2 #(.N_AXIS(7), .N_INST(1), .CNT_W(16), .EVT_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .threshold(threshold), .clear(clear),
    .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(iblk),
    .block(block), .block_axis_mask(axis_mask), .block_inst_mask(inst_mask),
    .block_event_count(evt8)
  );

  trigger_hls_deadlock_monitor_v2 #(.N_AXIS(7), .N_INST(1), .CNT_W(16), .EVT_W(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .threshold(threshold), .clear(clear),
    .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(iblk),
    .block(block2), .block_axis_mask(axis_mask2), .block_inst_mask(inst_mask2),
    .block_event_count(evt2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       blk;
    logic [6:0] am;
    logic [0:0] im;
    logic [7:0] e8;
    logic [1:0] e2;
  } exp_t;

  exp_t q[$];

  // Reference model: length of the current enabled stall run and detection history.
  bit         m_blk;
  int         m_run;
  logic [6:0] m_am;
  logic [0:0] m_im;
  int         m_e8;
  int         m_e2;

`ifdef DEADLOCK_MON_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_blk = 1'b0; m_run = 0; m_am = '0; m_im = '0; m_e8 = 0; m_e2 = 0;
  endtask

  // One clock edge of behaviour, evaluated on the inputs that edge will sample.
  task automatic model_step();
    bit stall, go;
    int thr;
    stall = (axis != 0) || ((iblk & ~idle) != 0);
    go    = stall && enable;
    thr   = (threshold == 0) ? 1 : int'(threshold);
    if (clear) begin
      m_blk = 1'b0; m_run = 0; m_am = '0; m_im = '0;
    end else if (m_blk) begin
      if (!STICKY && !go) begin
        m_blk = 1'b0; m_run = 0;
      end
    end else if (go) begin
      if (m_run < 65535) m_run++;
      if (m_run >= thr) begin
        m_blk = 1'b1;
        m_am  = axis;
        m_im  = iblk & ~idle;
        if (m_e8 < 255) m_e8++;
        if (m_e2 < 3)   m_e2++;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic step(input bit en, input int thr, input bit clr,
                      input logic [6:0] ax, input logic id, input logic ib);
    exp_t e;
    enable = en; threshold = 16'(thr); clear = clr; axis = ax; idle = id; iblk = ib;
    model_step();
    e.blk = m_blk; e.am = m_am; e.im = m_im; e.e8 = 8'(m_e8); e.e2 = 2'(m_e2);
    q.push_back(e);
    @(posedge clock); #1;
  endtask

  task automatic do_clear();
    step(1'b1, 1, 1'b1, 7'd0, 1'b0, 1'b0);
  endtask

  // Monitor: compares the outputs of every edge against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock); #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_block",     {31'd0, block},      {31'd0, e.blk});
        chk("sb_axis_mask", {25'd0, axis_mask},  {25'd0, e.am});
        chk("sb_inst_mask", {31'd0, inst_mask},  {31'd0, e.im});
        chk("sb_evt8",      {24'd0, evt8},       {24'd0, e.e8});
        chk("sb_evt2",      {30'd0, evt2},       {30'd0, e.e2});
        chk("sb_block2",    {31'd0, block2},     {31'd0, e.blk});
      end
    end
  end

  initial begin
    bit stalling;
    logic [6:0] ax;
    logic ib, id;
    reset_n = 1'b0; enable = 1'b0; threshold = '0; clear = 1'b0;
    axis = '0; idle = '0; iblk = '0;
    model_reset();
    #7;
    chk("rst_block",  {31'd0, block},     32'd0);
    chk("rst_amask",  {25'd0, axis_mask}, 32'd0);
    chk("rst_imask",  {31'd0, inst_mask}, 32'd0);
    chk("rst_evt",    {24'd0, evt8},      32'd0);
    #5 reset_n = 1'b1;

    // 1: single-cycle stall with threshold 1
    step(1, 1, 0, 7'b0000100, 0, 0);
    chk("t1_block", {31'd0, block},     32'd1);
    chk("t1_amask", {25'd0, axis_mask}, 32'b0000100);
    chk("t1_evt",   {24'd0, evt8},      32'd1);
    step(1, 1, 0, 7'd0, 0, 0);
    chk("t6_stall_end", {31'd0, block}, {31'd0, STICKY});
    do_clear();

    // 2: a 4-cycle run does not reach threshold 5; a 5-cycle run does
    repeat (4) step(1, 5, 0, 7'b0010000, 0, 0);
    step(1, 5, 0, 7'd0, 0, 0);
    repeat (4) step(1, 5, 0, 7'b0000001, 0, 0);
    chk("t2_no_block", {31'd0, block}, 32'd0);
    step(1, 5, 0, 7'b0000001, 0, 0);
    chk("t2_block", {31'd0, block}, 32'd1);
    do_clear();

    // 3: idle instances never stall
    repeat (20) step(1, 3, 0, 7'd0, 1, 1);
    chk("t3_idle", {31'd0, block}, 32'd0);
    repeat (3) step(1, 3, 0, 7'd0, 0, 1);
    chk("t3_block", {31'd0, block},     32'd1);
    chk("t3_imask", {31'd0, inst_mask}, 32'd1);
    do_clear();

    // 4: clear together with a held stall
    repeat (4) step(1, 3, 0, 7'b1000000, 0, 0);
    step(1, 3, 1, 7'b1000000, 0, 0);
    chk("t4_clr_block", {31'd0, block},     32'd0);
    chk("t4_clr_amask", {25'd0, axis_mask}, 32'd0);
    repeat (2) step(1, 3, 0, 7'b1000000, 0, 0);
    chk("t4_not_yet", {31'd0, block}, 32'd0);
    step(1, 3, 0, 7'b1000000, 0, 0);
    chk("t4_reblock", {31'd0, block}, 32'd1);
    chk("t4_evt",     {24'd0, evt8},  32'd5);
    do_clear();

    // 5: asynchronous reset in the middle of a count
    repeat (3) step(1, 8, 0, 7'b0000010, 0, 0);
    #4;
    reset_n = 1'b0;
    #1;
    chk("t5_block", {31'd0, block},     32'd0);
    chk("t5_amask", {25'd0, axis_mask}, 32'd0);
    chk("t5_evt",   {24'd0, evt8},      32'd0);
    chk("t5_evt2",  {30'd0, evt2},      32'd0);
    model_reset();
    #8 reset_n = 1'b1;
    repeat (7) step(1, 8, 0, 7'b0000010, 0, 0);
    chk("t5_resume_wait", {31'd0, block}, 32'd0);
    step(1, 8, 0, 7'b0000010, 0, 0);
    chk("t5_resume_block", {31'd0, block}, 32'd1);
    chk("t5_resume_evt",   {24'd0, evt8},  32'd1);
    do_clear();

    // 6: event counter saturation on the narrow instance
    repeat (5) begin
      step(1, 0, 0, 7'b0001000, 0, 0);
      do_clear();
    end
    chk("t6_evt2_sat", {30'd0, evt2}, 32'd3);
    chk("t6_evt8",     {24'd0, evt8}, 32'd6);

    // enable dropped while blocked
    step(1, 1, 0, 7'b0100000, 0, 0);
    step(0, 1, 0, 7'b0100000, 0, 0);
    chk("t6_en_off", {31'd0, block}, {31'd0, STICKY});
    do_clear();

    // randomized traffic
    stalling = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) stalling = ~stalling;
      ax = stalling ? 7'($urandom) : ((($urandom_range(0, 19)) == 0) ? 7'($urandom) : 7'd0);
      ib = 1'($urandom);
      id = stalling ? (($urandom_range(0, 3)) == 0) : 1'($urandom);
      step(($urandom_range(0, 19) != 0), $urandom_range(0, 6),
           ($urandom_range(0, 39) == 0), ax, id, ib);
    end

    repeat (2) @(posedge clock);
    #5;
    chk("drain", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
